// File: rtl/ram_dual_port.sv
// ram_dual_port: true dual-port synchronous RAM on one clock.
// Each port does one access per edge: a write (which also drives that
// port's q with the written data) or a read of the contents from before
// the edge. Port A wins a same-address write collision. The flop-based
// array and both outputs are cleared by the asynchronous reset.
module ram_dual_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] q_a_q, q_a_d;
    logic [DATA_WIDTH-1:0] q_b_q, q_b_d;

    // Next output per port: write-through on a write, old array word on a read
    always_comb begin
        q_a_d = we_a ? data_a : mem_q[addr_a];
        q_b_d = we_b ? data_b : mem_q[addr_b];
    end

    // Array update; A is applied after B so A's data survives a collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we_b) begin
                mem_q[addr_b] <= data_b;
            end
            if (we_a) begin
                mem_q[addr_a] <= data_a;
            end
        end
    end

    // Registered read data for both ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            q_a_q <= q_a_d;
            q_b_q <= q_b_d;
        end
    end

    assign q_a = q_a_q;
    assign q_b = q_b_q;

endmodule

// File: tb/tb_ram_dual_port.sv
// tb_ram_dual_port: directed vectors for ram_dual_port. The driver issues
// one access pair per cycle and queues the expected q_a/q_b; a separate
// monitor pops and compares shortly after each rising edge.
module tb_ram_dual_port;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic          we_a = 1'b0, we_b = 1'b0;
    logic [DW-1:0] q_a, q_b;

    ram_dual_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .data_a (data_a),
        .addr_a (addr_a),
        .we_a   (we_a),
        .q_a    (q_a),
        .data_b (data_b),
        .addr_b (addr_b),
        .we_b   (we_b),
        .q_b    (q_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } sb_item_t;

    sb_item_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Issue one access pair at the falling edge and queue the expected outputs
    task automatic op(input string name,
                      input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        sb_item_t it;
        @(negedge clk);
        we_a = wa; addr_a = aa; data_a = da;
        we_b = wb; addr_b = ab; data_b = db;
        it.name = name; it.exp_a = ea; it.exp_b = eb;
        sb.push_back(it);
    endtask

    task automatic idle();
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0;
    endtask

    // Monitor: compare the outputs produced by each issued access
    initial begin
        sb_item_t it;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check({it.name, ".q_a"}, q_a, it.exp_a);
                check({it.name, ".q_b"}, q_b, it.exp_b);
            end
        end
    end

    // Driver
    initial begin
        int waited;
        // power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("por.q_a", q_a, 8'h00);
        check("por.q_b", q_b, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        //  name          wa   aa     da     wb   ab     db     exp_a  exp_b
        op("wr_diff",     1, 6'h01, 8'h33, 1, 6'h02, 8'h44, 8'h33, 8'h44);
        op("wr_a_rd_b",   1, 6'h03, 8'h55, 0, 6'h01, 8'h00, 8'h55, 8'h33);
        op("rd_rd",       0, 6'h02, 8'h00, 0, 6'h03, 8'h00, 8'h44, 8'h55);
        op("rbw",         0, 6'h02, 8'h00, 1, 6'h02, 8'h77, 8'h44, 8'h77);
        op("rbw_after",   0, 6'h02, 8'h00, 0, 6'h02, 8'h00, 8'h77, 8'h77);
        op("collide",     1, 6'h10, 8'hAA, 1, 6'h10, 8'hBB, 8'hAA, 8'hBB);
        op("collide_rd",  0, 6'h10, 8'h00, 0, 6'h10, 8'h00, 8'hAA, 8'hAA);
        op("bound_wr",    1, 6'h3F, 8'hFF, 1, 6'h00, 8'h5A, 8'hFF, 8'h5A);
        op("bound_rd1",   0, 6'h00, 8'h00, 0, 6'h3F, 8'h00, 8'h5A, 8'hFF);
        op("bound_rd2",   0, 6'h3F, 8'h00, 0, 6'h00, 8'h00, 8'hFF, 8'h5A);
        op("neighbour",   0, 6'h3E, 8'h00, 0, 6'h01, 8'h00, 8'h00, 8'h33);
        op("neighbour2",  0, 6'h01, 8'h00, 0, 6'h3E, 8'h00, 8'h33, 8'h00);

        // asynchronous reset between edges; outputs must clear at once
        idle();
        rst = 1'b1;
        #1;
        check("arst.q_a", q_a, 8'h00);
        check("arst.q_b", q_b, 8'h00);
        // writes while reset is held must be ignored
        we_a = 1'b1; addr_a = 6'h07; data_a = 8'h99;
        we_b = 1'b1; addr_b = 6'h08; data_b = 8'h66;
        @(posedge clk);
        #1;
        check("arst_hold.q_a", q_a, 8'h00);
        check("arst_hold.q_b", q_b, 8'h00);
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0;
        rst = 1'b0;

        op("post_rst1",   0, 6'h01, 8'h00, 0, 6'h02, 8'h00, 8'h00, 8'h00);
        op("post_rst2",   0, 6'h03, 8'h00, 0, 6'h3F, 8'h00, 8'h00, 8'h00);
        op("post_rst3",   0, 6'h07, 8'h00, 0, 6'h08, 8'h00, 8'h00, 8'h00);
        op("post_wr",     1, 6'h05, 8'h12, 0, 6'h05, 8'h00, 8'h12, 8'h00);
        op("post_rd",     0, 6'h05, 8'h00, 0, 6'h05, 8'h00, 8'h12, 8'h12);
        idle();

        // drain the scoreboard with a bounded wait
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #5;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
